axi_lite_selftest_master: RTL and testbench

- Parametrised AXI4-Lite master that writes a generated data pattern to N consecutive slave registers, reads each one back and compares it.
- Reports done, error and a mismatch count.
- Successor to the fixed 4-word init/done/error master used in layer IP example designs; adds configurable count, stride, pattern, sequencing mode and error counting.
- Sits on the M00_AXI port of layer IPs for bring-up self-test against the IP's own S00_AXI register bank.

---
 rtl/axi_lite_selftest_master.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_selftest_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite bring-up master: writes a generated pattern to N consecutive slave registers,
// reads each one back and compares, reporting done, a sticky error and a saturating count.
module axi_lite_selftest_master #(
    parameter int unsigned                          C_M_AXI_ADDR_WIDTH   = 32,
    parameter int unsigned                          C_M_AXI_DATA_WIDTH   = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]        C_M_TARGET_BASE_ADDR = '0,
    parameter int unsigned                          C_M_TRANSACTIONS_NUM = 4,
    parameter int unsigned                          C_M_ADDR_STRIDE      = 4,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]        C_M_DATA_SEED        = 32'h0101FFFF,
    parameter int unsigned                          C_M_PATTERN_MODE     = 0,
    parameter int unsigned                          C_M_SEQ_MODE         = 0
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          INIT_AXI_TXN,
    output logic                          TXN_DONE,
    output logic                          ERROR,
    output logic [7:0]                    ERR_COUNT,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam logic [8:0]  LastIdx = 9'(C_M_TRANSACTIONS_NUM - 1);

    typedef enum logic [2:0] {StIdle, StWrAddr, StWrResp, StRdAddr, StRdData, StDone} state_t;

    state_t          r_state;
    logic            r_init;
    logic [8:0]      r_wi, r_ri;
    logic            r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready, r_arvalid, r_rready;
    logic [AW-1:0]   r_awaddr, r_araddr;
    logic [DW-1:0]   r_wdata;
    logic            r_done, r_error;
    logic [7:0]      r_err_count;

    function automatic logic [AW-1:0] f_addr(input logic [8:0] idx);
        return C_M_TARGET_BASE_ADDR + AW'(idx) * AW'(C_M_ADDR_STRIDE);
    endfunction

    function automatic logic [DW-1:0] f_pattern(input logic [8:0] idx);
        logic [2*DW-1:0] dbl;
        if (C_M_PATTERN_MODE == 1) begin
            // Shifting the doubled word left gives a rotate in the upper half.
            dbl = {C_M_DATA_SEED, C_M_DATA_SEED} << idx[4:0];
            return dbl[2*DW-1:DW];
        end
        return C_M_DATA_SEED + DW'(idx);
    endfunction

    logic       w_start, w_aw_ok, w_w_ok, w_rd_bad;
    logic [8:0] w_wi_nxt, w_ri_nxt;
    logic [7:0] w_err_sat;

    assign w_start   = INIT_AXI_TXN & ~r_init;
    assign w_aw_ok   = r_aw_done | (r_awvalid & M_AXI_AWREADY);
    assign w_w_ok    = r_w_done | (r_wvalid & M_AXI_WREADY);
    assign w_rd_bad  = (M_AXI_RRESP != 2'b00) | (M_AXI_RDATA != f_pattern(r_ri));
    assign w_wi_nxt  = r_wi + 9'd1;
    assign w_ri_nxt  = r_ri + 9'd1;
    assign w_err_sat = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state     <= StIdle;
            r_init      <= 1'b0;
            r_wi        <= '0;
            r_ri        <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_init <= INIT_AXI_TXN;
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_start) begin
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_count <= '0;
                        r_wi        <= '0;
                        r_ri        <= '0;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_awaddr    <= f_addr(9'd0);
                        r_wdata     <= f_pattern(9'd0);
                        r_state     <= StWrAddr;
                    end
                end
                StWrAddr: begin
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        r_wi     <= w_wi_nxt;
                        if (M_AXI_BRESP != 2'b00) begin
                            r_error     <= 1'b1;
                            r_err_count <= w_err_sat;
                        end
                        if (C_M_SEQ_MODE == 1 || r_wi == LastIdx) begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= f_addr(r_ri);
                            r_state   <= StRdAddr;
                        end else begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= f_addr(w_wi_nxt);
                            r_wdata   <= f_pattern(w_wi_nxt);
                            r_state   <= StWrAddr;
                        end
                    end
                end
                StRdAddr: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= StRdData;
                    end
                end
                StRdData: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        r_ri     <= w_ri_nxt;
                        // A beat with both a bad response and bad data counts once.
                        if (w_rd_bad) begin
                            r_error     <= 1'b1;
                            r_err_count <= w_err_sat;
                        end
                        if (r_ri == LastIdx) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else if (C_M_SEQ_MODE == 1) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_awaddr  <= f_addr(r_wi);
                            r_wdata   <= f_pattern(r_wi);
                            r_state   <= StWrAddr;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= f_addr(w_ri_nxt);
                            r_state   <= StRdAddr;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign TXN_DONE      = r_done;
    assign ERROR         = r_error;
    assign ERR_COUNT     = r_err_count;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Bench for axi_lite_selftest_master: three configurations against a RAM slave model,
// bus transactions checked in order against a scoreboard of expected writes and reads.
module tb_axi_lite_selftest_master;
    localparam int          NI     = 3;
    localparam logic [31:0] Seed   = 32'h0101FFFF;
    localparam logic [31:0] NoAddr = 32'hFFFF_FFFF;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        init    [NI];
    logic        done    [NI];
    logic        error   [NI];
    logic [7:0]  errcnt  [NI];
    logic [31:0] awaddr  [NI];
    logic [31:0] wdata   [NI];
    logic [31:0] araddr  [NI];
    logic [31:0] rdata   [NI];
    logic [2:0]  awprot  [NI];
    logic [2:0]  arprot  [NI];
    logic [3:0]  wstrb   [NI];
    logic [1:0]  bresp   [NI];
    logic [1:0]  rresp   [NI];
    logic        awvalid [NI], awready [NI], wvalid [NI], wready [NI];
    logic        bvalid  [NI], bready  [NI], arvalid [NI], arready [NI];
    logic        rvalid  [NI], rready  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        axi_lite_selftest_master #(
            .C_M_TARGET_BASE_ADDR (g == 2 ? 32'h40 : 32'h0),
            .C_M_TRANSACTIONS_NUM (g == 2 ? 1 : 4),
            .C_M_ADDR_STRIDE      (g == 2 ? 8 : 4),
            .C_M_PATTERN_MODE     (g == 1 ? 1 : 0),
            .C_M_SEQ_MODE         (g == 1 ? 1 : 0)
        ) u_dut (
            .M_AXI_ACLK    (clk),
            .M_AXI_ARESETN (rstn),
            .INIT_AXI_TXN  (init[g]),
            .TXN_DONE      (done[g]),
            .ERROR         (error[g]),
            .ERR_COUNT     (errcnt[g]),
            .M_AXI_AWADDR  (awaddr[g]),
            .M_AXI_AWPROT  (awprot[g]),
            .M_AXI_AWVALID (awvalid[g]),
            .M_AXI_AWREADY (awready[g]),
            .M_AXI_WDATA   (wdata[g]),
            .M_AXI_WSTRB   (wstrb[g]),
            .M_AXI_WVALID  (wvalid[g]),
            .M_AXI_WREADY  (wready[g]),
            .M_AXI_BRESP   (bresp[g]),
            .M_AXI_BVALID  (bvalid[g]),
            .M_AXI_BREADY  (bready[g]),
            .M_AXI_ARADDR  (araddr[g]),
            .M_AXI_ARPROT  (arprot[g]),
            .M_AXI_ARVALID (arvalid[g]),
            .M_AXI_ARREADY (arready[g]),
            .M_AXI_RDATA   (rdata[g]),
            .M_AXI_RRESP   (rresp[g]),
            .M_AXI_RVALID  (rvalid[g]),
            .M_AXI_RREADY  (rready[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Slave behaviour: 0 zero-wait, 1 random, 2 AW late, 3 W late, 4 slow B.
    int          ready_mode;
    logic [31:0] corrupt_addr, slverr_addr;
    logic [31:0] mem [256];
    logic [95:0] exp_q [$];

    bit          aw_got [NI], w_got [NI], b_pend [NI], b_fire [NI], r_pend [NI], r_fire [NI];
    bit          aw_stall [NI], w_stall [NI], ar_stall [NI];
    bit          aw_fprev [NI], w_fprev [NI], ar_fprev [NI];
    int          aw_cnt [NI], w_cnt [NI], b_cnt [NI], r_cnt [NI], outst [NI], wr_count [NI];
    logic [31:0] aw_a [NI], w_d [NI], b_addr [NI], r_addr [NI];
    logic [31:0] aw_prev [NI], w_prev [NI], ar_prev [NI];

    task automatic check_value(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [95:0] ev(input int g, input int kind, input logic [31:0] a,
                                       input logic [31:0] d);
        return {16'(g), 16'(kind), a, d};
    endfunction

    function automatic logic [31:0] exp_data(input int g, input int i);
        logic [31:0] v;
        v = Seed;
        if (g == 1) begin
            for (int k = 0; k < i % 32; k++) v = {v[30:0], v[31]};
        end else begin
            v = Seed + 32'(i);
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_addr(input int g, input int i);
        return (g == 2) ? 32'h40 + 32'(i * 8) : 32'(i * 4);
    endfunction

    function automatic logic ready_pick(input int cnt, input int slow_mode);
        if (ready_mode == 1) return 1'($urandom_range(0, 1));
        if (ready_mode == slow_mode) return cnt >= 3;
        return 1'b1;
    endfunction

    function automatic int resp_delay();
        if (ready_mode == 0) return 0;
        if (ready_mode == 4) return 7;
        return int'($urandom_range(0, 7));
    endfunction

    task automatic sb_pop(input logic [95:0] got);
        check_value("sb_nonempty", 96'(exp_q.size() != 0), 96'(1));
        if (exp_q.size() != 0) check_value("bus_txn", got, exp_q.pop_front());
    endtask

    task automatic slave_step(input int g);
        if (!rstn) begin
            awready[g] = 1'b0; wready[g] = 1'b0; arready[g] = 1'b0;
            bvalid[g]  = 1'b0; rvalid[g] = 1'b0; bresp[g] = 2'b00; rresp[g] = 2'b00;
            rdata[g]   = '0;
            aw_got[g] = 0; w_got[g] = 0; b_pend[g] = 0; b_fire[g] = 0; r_pend[g] = 0; r_fire[g] = 0;
            aw_stall[g] = 0; w_stall[g] = 0; ar_stall[g] = 0;
            aw_fprev[g] = 0; w_fprev[g] = 0; ar_fprev[g] = 0;
            aw_cnt[g] = 0; w_cnt[g] = 0; outst[g] = 0;
        end else begin
            if (b_fire[g]) begin bvalid[g] = 1'b0; b_fire[g] = 0; outst[g]--; end
            if (b_pend[g]) begin
                if (b_cnt[g] == 0) begin
                    bvalid[g] = 1'b1;
                    bresp[g]  = (b_addr[g] == slverr_addr) ? 2'b10 : 2'b00;
                    b_pend[g] = 0;
                end else b_cnt[g]--;
            end
            if (bvalid[g] && bready[g]) b_fire[g] = 1;

            if (r_fire[g]) begin rvalid[g] = 1'b0; r_fire[g] = 0; outst[g]--; end
            if (r_pend[g]) begin
                if (r_cnt[g] == 0) begin
                    rvalid[g] = 1'b1;
                    rresp[g]  = 2'b00;
                    rdata[g]  = (r_addr[g] == corrupt_addr) ? 32'hDEADBEEF : mem[r_addr[g][9:2]];
                    r_pend[g] = 0;
                end else r_cnt[g]--;
            end
            if (rvalid[g] && rready[g]) r_fire[g] = 1;

            if (aw_fprev[g]) check_value("awvalid_drop", 96'(awvalid[g]), 96'(0));
            else if (aw_stall[g])
                check_value("aw_stable", 96'({awvalid[g], awaddr[g]}), 96'({1'b1, aw_prev[g]}));
            aw_fprev[g] = 0; aw_stall[g] = 0;
            if (awvalid[g]) begin
                awready[g] = ready_pick(aw_cnt[g], 2);
                if (awready[g]) begin
                    check_value("aw_single_outst", 96'(outst[g]), 96'(0));
                    aw_got[g] = 1; aw_a[g] = awaddr[g]; aw_cnt[g] = 0; aw_fprev[g] = 1;
                end else begin
                    aw_cnt[g]++; aw_stall[g] = 1; aw_prev[g] = awaddr[g];
                end
            end else awready[g] = 1'b0;

            if (w_fprev[g]) check_value("wvalid_drop", 96'(wvalid[g]), 96'(0));
            else if (w_stall[g])
                check_value("w_stable", 96'({wvalid[g], wdata[g]}), 96'({1'b1, w_prev[g]}));
            w_fprev[g] = 0; w_stall[g] = 0;
            if (wvalid[g]) begin
                wready[g] = ready_pick(w_cnt[g], 3);
                if (wready[g]) begin
                    check_value("w_single_outst", 96'(outst[g]), 96'(0));
                    w_got[g] = 1; w_d[g] = wdata[g]; w_cnt[g] = 0; w_fprev[g] = 1;
                end else begin
                    w_cnt[g]++; w_stall[g] = 1; w_prev[g] = wdata[g];
                end
            end else wready[g] = 1'b0;

            if (aw_got[g] && w_got[g]) begin
                sb_pop(ev(g, 0, aw_a[g], w_d[g]));
                mem[aw_a[g][9:2]] = w_d[g];
                b_addr[g] = aw_a[g]; b_pend[g] = 1; b_cnt[g] = resp_delay();
                outst[g]++; wr_count[g]++;
                aw_got[g] = 0; w_got[g] = 0;
            end

            if (ar_fprev[g]) check_value("arvalid_drop", 96'(arvalid[g]), 96'(0));
            else if (ar_stall[g])
                check_value("ar_stable", 96'({arvalid[g], araddr[g]}), 96'({1'b1, ar_prev[g]}));
            ar_fprev[g] = 0; ar_stall[g] = 0;
            if (arvalid[g]) begin
                arready[g] = ready_pick(0, -1);
                if (arready[g]) begin
                    check_value("ar_single_outst", 96'(outst[g]), 96'(0));
                    sb_pop(ev(g, 1, araddr[g], 32'h0));
                    r_pend[g] = 1; r_cnt[g] = resp_delay(); r_addr[g] = araddr[g];
                    outst[g]++; ar_fprev[g] = 1;
                end else begin
                    ar_stall[g] = 1; ar_prev[g] = araddr[g];
                end
            end else arready[g] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) slave_step(g);
    end

    task automatic push_expected(input int g);
        int n;
        n = (g == 2) ? 1 : 4;
        if (g == 1) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(ev(g, 0, exp_addr(g, i), exp_data(g, i)));
                exp_q.push_back(ev(g, 1, exp_addr(g, i), 32'h0));
            end
        end else begin
            for (int i = 0; i < n; i++) exp_q.push_back(ev(g, 0, exp_addr(g, i), exp_data(g, i)));
            for (int i = 0; i < n; i++) exp_q.push_back(ev(g, 1, exp_addr(g, i), 32'h0));
        end
    endtask

    task automatic check_reset(input int g);
        check_value("rst_awvalid", 96'(awvalid[g]), 96'(0));
        check_value("rst_wvalid", 96'(wvalid[g]), 96'(0));
        check_value("rst_bready", 96'(bready[g]), 96'(0));
        check_value("rst_arvalid", 96'(arvalid[g]), 96'(0));
        check_value("rst_rready", 96'(rready[g]), 96'(0));
        check_value("rst_done", 96'(done[g]), 96'(0));
        check_value("rst_error", 96'(error[g]), 96'(0));
        check_value("rst_errcnt", 96'(errcnt[g]), 96'(0));
        check_value("rst_awaddr", 96'(awaddr[g]), 96'(0));
        check_value("rst_wdata", 96'(wdata[g]), 96'(0));
        check_value("rst_araddr", 96'(araddr[g]), 96'(0));
        check_value("awprot", 96'(awprot[g]), 96'(0));
        check_value("arprot", 96'(arprot[g]), 96'(0));
        check_value("wstrb", 96'(wstrb[g]), 96'(4'hF));
    endtask

    task automatic run_test(input int g, input int exp_errs, input bit toggle);
        int cyc;
        push_expected(g);
        @(negedge clk);
        init[g] = 1'b1;
        @(negedge clk);
        check_value("start_done_clr", 96'(done[g]), 96'(0));
        check_value("start_err_clr", 96'(error[g]), 96'(0));
        check_value("start_cnt_clr", 96'(errcnt[g]), 96'(0));
        init[g] = 1'b0;
        if (toggle) begin
            repeat (2) @(negedge clk);
            init[g] = 1'b1;
            repeat (2) @(negedge clk);
            init[g] = 1'b0;
        end
        cyc = 0;
        while (!done[g] && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_value("run_done", 96'(done[g]), 96'(1));
        check_value("run_error", 96'(error[g]), 96'(exp_errs != 0));
        check_value("run_errcnt", 96'(errcnt[g]), 96'(exp_errs));
        check_value("sb_drained", 96'(exp_q.size()), 96'(0));
        exp_q.delete();
        repeat (4) @(negedge clk);
        check_value("done_held", 96'(done[g]), 96'(1));
        check_value("error_held", 96'(error[g]), 96'(exp_errs != 0));
    endtask

    initial begin
        int base, cyc;
        for (int g = 0; g < NI; g++) init[g] = 1'b0;
        ready_mode   = 0;
        corrupt_addr = NoAddr;
        slverr_addr  = NoAddr;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rstn = 1'b1;
        @(negedge clk);

        run_test(0, 0, 0);
        run_test(1, 0, 0);
        run_test(2, 0, 0);

        corrupt_addr = 32'h8;
        slverr_addr  = 32'hC;
        run_test(0, 2, 0);
        corrupt_addr = NoAddr;
        slverr_addr  = NoAddr;
        run_test(0, 0, 1);

        ready_mode = 2;
        run_test(0, 0, 0);
        ready_mode = 3;
        run_test(0, 0, 0);
        ready_mode = 1;
        run_test(0, 0, 0);
        run_test(1, 0, 0);

        // Reset while the second write response is outstanding.
        ready_mode = 4;
        push_expected(0);
        base = wr_count[0];
        @(negedge clk);
        init[0] = 1'b1;
        @(negedge clk);
        init[0] = 1'b0;
        cyc = 0;
        while (!(wr_count[0] == base + 2 && bready[0]) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_value("reach_wr_resp1", 96'(wr_count[0] - base), 96'(2));
        check_value("in_wr_resp1", 96'(bready[0]), 96'(1));
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset(0);
        exp_q.delete();
        rstn = 1'b1;
        @(negedge clk);

        ready_mode = 0;
        run_test(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
